// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer, 1-cycle imem requests and tagged instruction FIFO to decode.
// Optional counters enabled by defining FETCH_PERF_EN.
`default_nettype none

module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        dec_ready,
   output logic        halted,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               halted_q;
   logic [31:0]        fetch_pc_q;
   logic               inflight_q;
   logic [31:0]        inflight_pc_q;
   logic [31:0]        pc_mem_q    [FIFO_DEPTH];
   logic [31:0]        instr_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic               pop;
   logic               push;
   logic               issue;
   logic [CNT_W-1:0]   used_slots;
   logic [1:0]         unused_redir_lsb;

   assign unused_redir_lsb = redirect_pc[1:0];

   assign out_valid = (count_q != '0);
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign halted    = halted_q;

   assign pop = out_valid && dec_ready;

   // A slot being popped this cycle is already free for the request issued now.
   assign used_slots = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
   assign issue      = reset && (state_q == ST_RUN) && !halt_req && !redirect_valid &&
                       (used_slots < CNT_W'(FIFO_DEPTH));
   assign push       = inflight_q && !redirect_valid;

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (halt_req) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!halt_req)                           state_d = ST_RUN;
            else if (!inflight_q && count_q == '0)   state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (!halt_req) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         halted_q      <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         halted_q   <= (state_d == ST_HALTED);
         inflight_q <= issue;
         if (issue) begin
            inflight_pc_q <= fetch_pc_q;
            fetch_pc_q    <= fetch_pc_q + 32'd4;
         end
         // Redirect flushes the buffer and drops the response landing this cycle.
         if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
         end else begin
            if (push) begin
               pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
               instr_mem_q[wr_ptr_q] <= imem_rdata;
               wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (pop)                             perf_fetched_q <= perf_fetched_q + 32'd1;
         if (!out_valid && state_q == ST_RUN) perf_stall_q   <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`else
   assign perf_fetched = 32'd0;
   assign perf_stall   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl (default and wrapping RESET_PC instances).
`default_nettype none

module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        dec_ready;

   logic        imem_req, out_valid, halted;
   logic [31:0] imem_addr, imem_rdata, out_pc, out_instr, perf_fetched, perf_stall;

   logic        imem_req_w, out_valid_w, halted_w;
   logic [31:0] imem_addr_w, imem_rdata_w, out_pc_w, out_instr_w, perf_fetched_w, perf_stall_w;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .dec_ready(dec_ready),
      .halted(halted), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
      .out_valid(out_valid_w), .out_pc(out_pc_w), .out_instr(out_instr_w), .dec_ready(dec_ready),
      .halted(halted_w), .perf_fetched(perf_fetched_w), .perf_stall(perf_stall_w)
   );

   // Instruction memory model: word at address A reads as ~A, one cycle after the request.
   always @(posedge clk) begin
      if (imem_req)   imem_rdata   <= ~imem_addr;
      if (imem_req_w) imem_rdata_w <= ~imem_addr_w;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt_req       = 1'b0;
      dec_ready      = rdy;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; dec_ready = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if ({imem_req, imem_addr, out_valid, out_pc, out_instr, halted} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0})
         $display("FAIL reset_outputs: req=%b addr=%h valid=%b pc=%h instr=%h halted=%b expected 0 0 0 0 0 0",
                  imem_req, imem_addr, out_valid, out_pc, out_instr, halted);
      else n_pass++;
      n_total++;
      if ({perf_fetched, perf_stall} !== 64'h0)
         $display("FAIL reset_perf: fetched=%0d stall=%0d expected 0 0", perf_fetched, perf_stall);
      else n_pass++;
      n_total++;
      if ({imem_req_w, imem_addr_w} !== {1'b0, 32'hFFFF_FFF8})
         $display("FAIL reset_pc_param: req=%b addr=%h expected 0 fffffff8", imem_req_w, imem_addr_w);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      do_reset(1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         e = 32'(4 * c);
         n_total++;
         if ({imem_req, imem_addr} !== {1'b1, e})
            $display("FAIL stream_req c%0d: req=%b addr=%h expected 1 %h", c, imem_req, imem_addr, e);
         else n_pass++;
         n_total++;
         if (c < 2) begin
            if (out_valid !== 1'b0) $display("FAIL stream_empty c%0d: valid=%b expected 0", c, out_valid);
            else n_pass++;
         end else begin
            e = 32'(4 * (c - 2));
            if ({out_valid, out_pc, out_instr} !== {1'b1, e, ~e})
               $display("FAIL stream_out c%0d: valid=%b pc=%h instr=%h expected 1 %h %h", c, out_valid, out_pc, out_instr, e, ~e);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      do_reset(1'b0);
      for (int c = 0; c < 7; c++) begin
         #1;
         n_total++;
         if (c < 2) begin
            e = 32'(4 * c);
            if ({imem_req, imem_addr} !== {1'b1, e})
               $display("FAIL stall_req c%0d: req=%b addr=%h expected 1 %h", c, imem_req, imem_addr, e);
            else n_pass++;
         end else begin
            if ({imem_req, out_valid, out_pc, out_instr} !== {1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF})
               $display("FAIL stall_hold c%0d: req=%b valid=%b pc=%h instr=%h expected 0 1 0 ffffffff",
                        c, imem_req, out_valid, out_pc, out_instr);
            else n_pass++;
         end
         tick();
      end
      dec_ready = 1'b1;
      for (int c = 7; c < 11; c++) begin
         #1;
         e = 32'(4 * (c - 7));
         n_total++;
         if ({out_valid, out_pc, out_instr} !== {1'b1, e, ~e})
            $display("FAIL stall_resume c%0d: valid=%b pc=%h instr=%h expected 1 %h %h", c, out_valid, out_pc, out_instr, e, ~e);
         else n_pass++;
         if (c == 7) begin
            n_total++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h8})
               $display("FAIL stall_reissue: req=%b addr=%h expected 1 00000008", imem_req, imem_addr);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b1);
      tick(); tick(); tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      #1;
      n_total++;
      if ({imem_req, out_valid, out_pc} !== {1'b0, 1'b1, 32'h4})
         $display("FAIL redir_cycle: req=%b valid=%b pc=%h expected 0 1 00000004", imem_req, out_valid, out_pc);
      else n_pass++;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_total++;
      if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100})
         $display("FAIL redir_flush: valid=%b req=%b addr=%h expected 0 1 00000100", out_valid, imem_req, imem_addr);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({out_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h104})
         $display("FAIL redir_drop: valid=%b req=%b addr=%h expected 0 1 00000104", out_valid, imem_req, imem_addr);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h100, ~32'h100})
         $display("FAIL redir_first: valid=%b pc=%h instr=%h expected 1 00000100 fffffeff", out_valid, out_pc, out_instr);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({out_valid, out_pc} !== {1'b1, 32'h104})
         $display("FAIL redir_second: valid=%b pc=%h expected 1 00000104", out_valid, out_pc);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      logic [31:0] base;
      base = 32'hFFFF_FFF8;
      do_reset(1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         if (c < 3) begin
            e = base + 32'(4 * c);
            n_total++;
            if ({imem_req_w, imem_addr_w} !== {1'b1, e})
               $display("FAIL wrap_req c%0d: req=%b addr=%h expected 1 %h", c, imem_req_w, imem_addr_w, e);
            else n_pass++;
         end
         if (c >= 2) begin
            e = base + 32'(4 * (c - 2));
            n_total++;
            if ({out_valid_w, out_pc_w, out_instr_w} !== {1'b1, e, ~e})
               $display("FAIL wrap_out c%0d: valid=%b pc=%h instr=%h expected 1 %h %h", c, out_valid_w, out_pc_w, out_instr_w, e, ~e);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_halt();
      do_reset(1'b1);
      tick(); tick(); tick();
      halt_req = 1'b1;
      #1;
      n_total++;
      if ({imem_req, out_valid, out_pc, halted} !== {1'b0, 1'b1, 32'h4, 1'b0})
         $display("FAIL halt_c3: req=%b valid=%b pc=%h halted=%b expected 0 1 00000004 0", imem_req, out_valid, out_pc, halted);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({imem_req, out_valid, out_pc, halted} !== {1'b0, 1'b1, 32'h8, 1'b0})
         $display("FAIL halt_c4: req=%b valid=%b pc=%h halted=%b expected 0 1 00000008 0", imem_req, out_valid, out_pc, halted);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({imem_req, out_valid, halted} !== 3'b000)
         $display("FAIL halt_c5: req=%b valid=%b halted=%b expected 0 0 0", imem_req, out_valid, halted);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({imem_req, halted} !== 2'b01)
         $display("FAIL halt_c6: req=%b halted=%b expected 0 1", imem_req, halted);
      else n_pass++;
      tick();
      halt_req = 1'b0;
      #1;
      n_total++;
      if ({imem_req, halted} !== 2'b01)
         $display("FAIL halt_c7: req=%b halted=%b expected 0 1", imem_req, halted);
      else n_pass++;
      tick();
      #1;
      n_total++;
      if ({imem_req, imem_addr, halted} !== {1'b1, 32'hC, 1'b0})
         $display("FAIL halt_resume: req=%b addr=%h halted=%b expected 1 0000000c 0", imem_req, imem_addr, halted);
      else n_pass++;
   endtask

   task automatic test_perf();
      logic [31:0] exp_f, exp_s;
`ifdef FETCH_PERF_EN
      exp_f = 32'd10;
      exp_s = 32'd4;
`else
      exp_f = 32'd0;
      exp_s = 32'd0;
`endif
      do_reset(1'b1);
      for (int c = 0; c < 12; c++) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      dec_ready      = 1'b0;
      tick();
      redirect_valid = 1'b0;
      tick(); tick();
      #1;
      n_total++;
      if ({perf_fetched, perf_stall} !== {exp_f, exp_s})
         $display("FAIL perf_counts: fetched=%0d stall=%0d expected %0d %0d", perf_fetched, perf_stall, exp_f, exp_s);
      else n_pass++;
      n_total++;
      if ({out_valid, out_pc} !== {1'b1, 32'h40})
         $display("FAIL perf_redirect_out: valid=%b pc=%h expected 1 00000040", out_valid, out_pc);
      else n_pass++;
      // Asynchronous reset mid-stream must clear everything without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      n_total++;
      if ({out_valid, imem_req, imem_addr, perf_fetched, perf_stall} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0})
         $display("FAIL async_reset: valid=%b req=%b addr=%h fetched=%0d stall=%0d expected 0 0 0 0 0",
                  out_valid, imem_req, imem_addr, perf_fetched, perf_stall);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_perf();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
